// File: rtl/uart_frame_engine.sv
// Full-duplex UART: shared baud tick, TX and RX frame engines.
// RX has 2-flop sync, 3-sample majority, false-start rejection.
module uart_frame_engine #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 txd,
  input  logic                 rxd,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int DIV = CLK_HZ / (BAUD * OVS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(OVS);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] OVS_LAST = CW'(OVS - 1);
  localparam logic [CW-1:0] MID_DEC  = CW'(OVS / 2 + 1);
  localparam logic [3:0]    DB_LAST  = 4'(DATA_BITS - 1);
  localparam logic HAS_PAR   = (PARITY != 0);
  localparam logic ODD       = (PARITY == 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= (div_cnt == DIV_LAST);
      if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + 1'b1;
    end
  end

  state_t                 tx_st;
  logic [CW-1:0]          tx_cnt;
  logic [3:0]             tx_bit;
  logic [DATA_BITS-1:0]   tx_sh;
  logic                   tx_par;
  logic                   tx_stop;
  logic                   tx_last;
  logic                   tx_adv;

  assign tx_last = (tx_cnt == OVS_LAST);
  assign tx_adv  = tick && tx_last;

  // tx_busy stays high through the tx_done cycle; accept needs busy low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st   <= S_IDLE;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
      tx_par  <= 1'b0;
      tx_stop <= 1'b0;
      txd     <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tick && tx_st != S_IDLE)
        tx_cnt <= tx_last ? '0 : tx_cnt + 1'b1;
      unique case (tx_st)
        S_IDLE: begin
          txd <= 1'b1;
          if (tx_busy) begin
            tx_busy <= 1'b0;
          end else if (tx_start) begin
            tx_sh   <= tx_data;
            tx_par  <= (^tx_data) ^ ODD;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_stop <= 1'b0;
            tx_busy <= 1'b1;
            txd     <= 1'b0;
            tx_st   <= S_START;
          end
        end
        S_START: begin
          if (tx_adv) begin
            txd   <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
            tx_st <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx_adv) begin
            if (tx_bit == DB_LAST) begin
              if (HAS_PAR) begin
                txd   <= tx_par;
                tx_st <= S_PAR;
              end else begin
                txd   <= 1'b1;
                tx_st <= S_STOP;
              end
            end else begin
              tx_bit <= tx_bit + 4'd1;
              txd    <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
            end
          end
        end
        S_PAR: begin
          if (tx_adv) begin
            txd   <= 1'b1;
            tx_st <= S_STOP;
          end
        end
        S_STOP: begin
          if (tx_adv) begin
            if (tx_stop == STOP_LAST) begin
              tx_st   <= S_IDLE;
              tx_done <= 1'b1;
            end else begin
              tx_stop <= 1'b1;
            end
          end
        end
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  logic rx_line;
  logic sync1;
  logic rx_in;

  assign rx_line = loopback ? txd : rxd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_in <= 1'b1;
    end else begin
      sync1 <= rx_line;
      rx_in <= sync1;
    end
  end

  state_t                 rx_st;
  logic [CW-1:0]          rx_cnt;
  logic [3:0]             rx_bit;
  logic [DATA_BITS-1:0]   rx_sh;
  logic [1:0]             rx_hist;
  logic                   rx_perr_q;
  logic                   rx_last;
  logic                   rx_adv;
  logic                   rx_mid;
  logic                   maj;

  assign rx_last = (rx_cnt == OVS_LAST);
  assign rx_adv  = tick && rx_last;
  assign rx_mid  = tick && (rx_cnt == MID_DEC);
  assign maj = (rx_hist[1] & rx_hist[0]) |
               (rx_hist[1] & rx_in) |
               (rx_hist[0] & rx_in);

  // rx_hist holds the two previous tick samples for the vote
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_st         <= S_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_sh         <= '0;
      rx_hist       <= 2'b11;
      rx_perr_q     <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (tick) rx_hist <= {rx_hist[0], rx_in};
      if (tick && rx_st != S_IDLE)
        rx_cnt <= rx_last ? '0 : rx_cnt + 1'b1;
      unique case (rx_st)
        S_IDLE: begin
          if (!rx_in) begin
            rx_st  <= S_START;
            rx_cnt <= '0;
            rx_bit <= '0;
          end
        end
        S_START: begin
          if (rx_mid && maj) rx_st <= S_IDLE;
          else if (rx_adv)   rx_st <= S_DATA;
        end
        S_DATA: begin
          if (rx_mid) rx_sh <= {maj, rx_sh[DATA_BITS-1:1]};
          if (rx_adv) begin
            if (rx_bit == DB_LAST)
              rx_st <= HAS_PAR ? S_PAR : S_STOP;
            else
              rx_bit <= rx_bit + 4'd1;
          end
        end
        S_PAR: begin
          if (rx_mid) rx_perr_q <= maj ^ (^rx_sh) ^ ODD;
          if (rx_adv) rx_st <= S_STOP;
        end
        S_STOP: begin
          if (rx_mid) begin
            rx_data       <= rx_sh;
            rx_parity_err <= HAS_PAR && rx_perr_q;
            rx_frame_err  <= !maj;
            rx_done       <= 1'b1;
            rx_st         <= S_IDLE;
          end
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_engine.sv
// Bench for uart_frame_engine: 8N1 instance (a) and 7E2 instance (b)
// checked against a frame-level line model and expected-frame queues.
module tb_uart_frame_engine;

  localparam int OVS = 16;
  localparam int DIV = 4;
  localparam int BIT = OVS * DIV;
  localparam int CLK = 9600 * OVS * DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_start = 0, a_busy, a_done, a_txd;
  logic       a_rxd = 1, a_loop = 1, a_rdone, a_perr, a_ferr;
  logic [7:0] a_data = 0, a_rdata;
  logic       b_start = 0, b_busy, b_done, b_txd;
  logic       b_rxd = 1, b_loop = 1, b_rdone, b_perr, b_ferr;
  logic [6:0] b_data = 0, b_rdata;

  uart_frame_engine #(
    .CLK_HZ(CLK), .BAUD(9600), .OVS(OVS),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .reset(reset), .tx_start(a_start),
    .tx_data(a_data), .tx_busy(a_busy), .tx_done(a_done),
    .txd(a_txd), .rxd(a_rxd), .loopback(a_loop),
    .rx_data(a_rdata), .rx_done(a_rdone),
    .rx_parity_err(a_perr), .rx_frame_err(a_ferr)
  );

  uart_frame_engine #(
    .CLK_HZ(CLK), .BAUD(9600), .OVS(OVS),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .reset(reset), .tx_start(b_start),
    .tx_data(b_data), .tx_busy(b_busy), .tx_done(b_done),
    .txd(b_txd), .rxd(b_rxd), .loopback(b_loop),
    .rx_data(b_rdata), .rx_done(b_rdone),
    .rx_parity_err(b_perr), .rx_frame_err(b_ferr)
  );

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } rx_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ndone_a = 0, ndone_b = 0;
  int nrx_a = 0, nrx_b = 0;
  logic [1:0] tx_en = 2'b11;
  logic [8:0] txq_a[$];
  logic [8:0] txq_b[$];
  rx_t rxq_a[$];
  rx_t rxq_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int db(int s);
    return (s == 0) ? 8 : 7;
  endfunction
  function automatic int par(int s);
    return (s == 0) ? 0 : 2;
  endfunction
  function automatic int nbits(int s);
    return (s == 0) ? 10 : 11;
  endfunction

  // expected line level of bit i of a frame carrying d
  function automatic logic fbit(int s, logic [8:0] d, int i);
    int ones;
    ones = 0;
    if (i == 0) return 1'b0;
    if (i <= db(s)) return d[i-1];
    if (par(s) != 0 && i == db(s) + 1) begin
      for (int j = 0; j < db(s); j++) ones += int'(d[j]);
      if (par(s) == 2) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  function automatic logic sig(int s, int k);
    case (k)
      0: return (s == 0) ? a_busy : b_busy;
      1: return (s == 0) ? a_done : b_done;
      2: return (s == 0) ? a_rdone : b_rdone;
      default: return (s == 0) ? a_txd : b_txd;
    endcase
  endfunction

  task automatic wait_for(int s, int k, logic v, int max, string nm);
    int n;
    n = 0;
    while (sig(s, k) !== v && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " timeout"}, sig(s, k), v);
  endtask

  task automatic tx_mon(int s);
    logic [11:0] gv, ev;
    logic [8:0]  d;
    logic        have;
    int          nb;
    forever begin
      @(negedge clk);
      if (tx_en[s] && !reset && sig(s, 3) == 1'b0) begin
        nb = nbits(s);
        have = (s == 0) ? (txq_a.size() > 0) : (txq_b.size() > 0);
        chk($sformatf("txd frame %0d expected", s), have, 1);
        d = '0;
        if (have) d = (s == 0) ? txq_a.pop_front() : txq_b.pop_front();
        gv = '0;
        ev = '0;
        repeat (BIT / 2 - 2) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
          gv[i] = sig(s, 3);
          ev[i] = fbit(s, d, i);
          if (i < nb - 1) repeat (BIT) @(negedge clk);
        end
        if (have) chk($sformatf("txd frame %0d bits", s), gv, ev);
      end
    end
  endtask

  initial tx_mon(0);
  initial tx_mon(1);

  always @(negedge clk) begin : mon
    rx_t e;
    if (a_rdone) begin
      nrx_a++;
      chk("rx_done a expected", rxq_a.size() > 0, 1);
      if (rxq_a.size() > 0) begin
        e = rxq_a.pop_front();
        chk("rx_data a", 32'(a_rdata), 32'(e.d));
        chk("rx_parity_err a", a_perr, e.pe);
        chk("rx_frame_err a", a_ferr, e.fe);
      end
    end
    if (b_rdone) begin
      nrx_b++;
      chk("rx_done b expected", rxq_b.size() > 0, 1);
      if (rxq_b.size() > 0) begin
        e = rxq_b.pop_front();
        chk("rx_data b", 32'(b_rdata), 32'(e.d));
        chk("rx_parity_err b", b_perr, e.pe);
        chk("rx_frame_err b", b_ferr, e.fe);
      end
    end
    if (!a_busy) chk("txd a idle", a_txd, 1);
    if (!b_busy) chk("txd b idle", b_txd, 1);
    if (a_done) begin
      ndone_a++;
      chk("busy at done a", a_busy, 1);
    end
    if (b_done) begin
      ndone_b++;
      chk("busy at done b", b_busy, 1);
    end
  end

  task automatic send(int s, logic [8:0] d, logic lb);
    rx_t e;
    e.d = d;
    e.pe = 1'b0;
    e.fe = 1'b0;
    if (s == 0) begin
      txq_a.push_back(d);
      if (lb) rxq_a.push_back(e);
      a_data = d[7:0];
      a_start = 1'b1;
    end else begin
      txq_b.push_back(d);
      if (lb) rxq_b.push_back(e);
      b_data = d[6:0];
      b_start = 1'b1;
    end
    wait_for(s, 0, 1'b1, 100, "accept");
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic drive_rx(int s, logic [8:0] d, bit pflip,
                          bit stop0, int gbit);
    logic v;
    for (int i = 0; i < nbits(s); i++) begin
      v = fbit(s, d, i);
      if (pflip && i == db(s) + 1) v = ~v;
      if (stop0 && i == db(s) + (par(s) != 0 ? 1 : 0) + 1) v = 1'b0;
      if (s == 0) a_rxd = v;
      else        b_rxd = v;
      if (i == gbit) begin
        repeat (34) @(negedge clk);
        if (s == 0) a_rxd = ~v;
        else        b_rxd = ~v;
        repeat (4) @(negedge clk);
        if (s == 0) a_rxd = v;
        else        b_rxd = v;
        repeat (26) @(negedge clk);
      end else if (v == 1'b0 && stop0 && i == nbits(s) - 1) begin
        repeat (48) @(negedge clk);
        if (s == 0) a_rxd = 1'b1;
        else        b_rxd = 1'b1;
        repeat (16) @(negedge clk);
      end else begin
        repeat (BIT) @(negedge clk);
      end
    end
    a_rxd = 1'b1;
    b_rxd = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, n, nd, nr;
    rx_t e;
    repeat (3) @(negedge clk);
    chk("reset txd a", a_txd, 1);
    chk("reset busy a", a_busy, 0);
    chk("reset done a", a_done, 0);
    chk("reset rx_done a", a_rdone, 0);
    chk("reset rx_data a", a_rdata, 0);
    chk("reset errs a", {a_perr, a_ferr}, 0);
    chk("reset txd b", b_txd, 1);
    chk("reset rx_data b", b_rdata, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: loopback A5, line timing
    send(0, 9'h0A5, 1'b1);
    t0 = cyc;
    wait_for(0, 3, 1'b1, 200, "t1 bit0 high");
    wait_for(0, 3, 1'b0, 200, "t1 bit1 low");
    n = 0;
    while (a_txd == 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t1 bit width", n, 64);
    wait_for(0, 1, 1'b1, 1000, "t1 tx_done");
    t1 = cyc;
    chk("t1 frame length", (t1 - t0 >= 636) && (t1 - t0 <= 641), 1);
    repeat (4) @(negedge clk);
    chk("t1 rx_data", a_rdata, 8'hA5);
    chk("t1 errs", {a_perr, a_ferr}, 0);

    // 2: 7E2 loopback 41, then flipped parity on rxd
    send(1, 9'h041, 1'b1);
    repeat (30 + 8 * BIT) @(negedge clk);
    chk("t2 parity bit", b_txd, 0);
    repeat (BIT) @(negedge clk);
    chk("t2 stop1", b_txd, 1);
    repeat (BIT) @(negedge clk);
    chk("t2 stop2", b_txd, 1);
    wait_for(1, 1, 1'b1, 200, "t2 tx_done");
    repeat (4) @(negedge clk);
    chk("t2 rx_data", b_rdata, 7'h41);
    chk("t2 parity ok", b_perr, 0);
    b_loop = 1'b0;
    e = '{d: 9'h041, pe: 1'b1, fe: 1'b0};
    rxq_b.push_back(e);
    drive_rx(1, 9'h041, 1'b1, 1'b0, -1);
    chk("t2 parity err", b_perr, 1);
    b_loop = 1'b1;

    // 3: false start, then a centre glitch
    a_loop = 1'b0;
    repeat (BIT) @(negedge clk);
    nr = nrx_a;
    a_rxd = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    a_rxd = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("t3 false start", nrx_a - nr, 0);
    e = '{d: 9'h05A, pe: 1'b0, fe: 1'b0};
    rxq_a.push_back(e);
    drive_rx(0, 9'h05A, 1'b0, 1'b0, 3);
    chk("t3 glitch data", a_rdata, 8'h5A);

    // 4: framing error, then a clean frame clears it
    e = '{d: 9'h0C3, pe: 1'b0, fe: 1'b1};
    rxq_a.push_back(e);
    drive_rx(0, 9'h0C3, 1'b0, 1'b1, -1);
    chk("t4 frame err", a_ferr, 1);
    chk("t4 data", a_rdata, 8'hC3);
    e = '{d: 9'h03C, pe: 1'b0, fe: 1'b0};
    rxq_a.push_back(e);
    drive_rx(0, 9'h03C, 1'b0, 1'b0, -1);
    chk("t4 frame err cleared", a_ferr, 0);
    a_loop = 1'b1;
    repeat (BIT) @(negedge clk);

    // 5: tx_start held across three frames
    nd = ndone_a;
    e = '{d: 9'h000, pe: 1'b0, fe: 1'b0};
    txq_a.push_back(9'h000);
    rxq_a.push_back(e);
    e.d = 9'h0FF;
    txq_a.push_back(9'h0FF);
    rxq_a.push_back(e);
    e.d = 9'h055;
    txq_a.push_back(9'h055);
    rxq_a.push_back(e);
    a_data = 8'h00;
    a_start = 1'b1;
    wait_for(0, 0, 1'b1, 100, "t5 accept0");
    t0 = cyc;
    a_data = 8'hFF;
    wait_for(0, 1, 1'b1, 1000, "t5 done0");
    wait_for(0, 0, 1'b0, 10, "t5 idle0");
    wait_for(0, 0, 1'b1, 10, "t5 accept1");
    a_data = 8'h55;
    wait_for(0, 1, 1'b1, 1000, "t5 done1");
    wait_for(0, 0, 1'b0, 10, "t5 idle1");
    wait_for(0, 0, 1'b1, 10, "t5 accept2");
    wait_for(0, 1, 1'b1, 1000, "t5 done2");
    a_start = 1'b0;
    t1 = cyc;
    chk("t5 gapless", (t1 - t0 >= 1913) && (t1 - t0 <= 1926), 1);
    repeat (5) @(negedge clk);
    chk("t5 done count", ndone_a - nd, 3);
    chk("t5 idle after", a_busy, 0);

    nd = ndone_a;
    send(0, 9'h081, 1'b1);
    repeat (200) @(negedge clk);
    a_data = 8'h7E;
    a_start = 1'b1;
    repeat (2) @(negedge clk);
    a_start = 1'b0;
    wait_for(0, 1, 1'b1, 1000, "t5 done ign");
    repeat (2 * BIT) @(negedge clk);
    chk("t5 ignored start", ndone_a - nd, 1);
    chk("t5 ignored rx", a_rdata, 8'h81);

    // 6: reset mid-frame on both engines
    tx_en = 2'b00;
    a_data = 8'hA5;
    b_data = 7'h41;
    a_start = 1'b1;
    b_start = 1'b1;
    wait_for(0, 0, 1'b1, 100, "t6 accept a");
    wait_for(1, 0, 1'b1, 100, "t6 accept b");
    a_start = 1'b0;
    b_start = 1'b0;
    repeat (300) @(negedge clk);
    nd = ndone_a + ndone_b;
    nr = nrx_a + nrx_b;
    reset = 1'b1;
    #1;
    chk("t6 txd a", a_txd, 1);
    chk("t6 txd b", b_txd, 1);
    chk("t6 busy a", a_busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (800) @(negedge clk);
    chk("t6 no tx_done", ndone_a + ndone_b - nd, 0);
    chk("t6 no rx_done", nrx_a + nrx_b - nr, 0);
    chk("t6 rx_data cleared", a_rdata, 0);
    tx_en = 2'b11;
    send(0, 9'h03C, 1'b1);
    wait_for(0, 1, 1'b1, 1000, "t6 tx_done");
    repeat (4) @(negedge clk);
    chk("t6 rx_data", a_rdata, 8'h3C);

    repeat (2 * BIT) @(negedge clk);
    chk("txq a drained", txq_a.size(), 0);
    chk("txq b drained", txq_b.size(), 0);
    chk("rxq a drained", rxq_a.size(), 0);
    chk("rxq b drained", rxq_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
